// File: rtl/heap_sched_pkg.sv
// rtl/heap_sched_pkg.sv - shared op codes, FSM encoding and occupancy width helper for heap_op_scheduler
package heap_sched_pkg;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_t;

  // Counter must represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant over NUM_REQ requesters; pointer moves past the id just served
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [ID_W-1:0]    served_id,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_req
);

  logic [ID_W-1:0] ptr_q;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input logic [ID_W:0]   offs);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + offs;
    if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
    return sum[ID_W-1:0];
  endfunction

  always_comb begin
    logic [ID_W-1:0] idx;
    logic            found;
    grant    = '0;
    grant_id = '0;
    any_req  = |req;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = wrap_add(ptr_q, (ID_W+1)'(k));
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= wrap_add(served_id, (ID_W+1)'(1));
    end
  end

endmodule

// File: rtl/heap_op_scheduler.sv
// rtl/heap_op_scheduler.sv - arbitrates push/pop requests onto one shared max-heap unit and routes completions back
// Optional WAIT watchdog: define HEAP_SCHED_TIMEOUT_EN.
module heap_op_scheduler
  import heap_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int HEAP_DEPTH  = 25,
  parameter int TIMEOUT_CYC = 64,
  localparam int ID_W  = $clog2(NUM_REQ),
  localparam int OCC_W = occ_width(HEAP_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      heap_cmd_valid,
  output logic                      heap_cmd_op,
  output logic [DATA_W-1:0]         heap_cmd_data,
  input  logic                      heap_cmd_ready,
  input  logic                      heap_done,
  input  logic [DATA_W-1:0]         heap_pop_data,
  output logic [OCC_W-1:0]          occupancy,
  output logic                      busy,
  output logic                      timeout_flag
);

  sched_state_t       state_q, state_d;
  logic [ID_W-1:0]    id_q;
  logic               op_q;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               err_q;
  logic [OCC_W-1:0]   occ_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               any_req;
  logic               advance;
  logic               grant_op;
  logic               reject;
  logic               timed_out;
  logic [DATA_W-1:0]  req_data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign req_data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (advance),
    .served_id (id_q),
    .grant     (grant),
    .grant_id  (grant_id),
    .any_req   (any_req)
  );

  assign grant_op = req_op[grant_id];
  // Full/empty rejects never reach the heap, so occupancy stays within 0..HEAP_DEPTH.
  assign reject   = (grant_op == OP_PUSH) ? (occ_q == OCC_W'(HEAP_DEPTH)) : (occ_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    req_ready      = '0;
    rsp_valid      = '0;
    rsp_data       = '0;
    rsp_err        = 1'b0;
    heap_cmd_valid = 1'b0;
    advance        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          req_ready = grant;
          state_d   = reject ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        heap_cmd_valid = 1'b1;
        if (heap_cmd_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (heap_done || timed_out) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = NUM_REQ'(1) << id_q;
        rsp_data  = rsp_data_q;
        rsp_err   = err_q;
        advance   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q       <= '0;
      op_q       <= OP_PUSH;
      data_q     <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
      occ_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            id_q       <= grant_id;
            op_q       <= grant_op;
            data_q     <= req_data_arr[grant_id];
            rsp_data_q <= '0;
            err_q      <= reject;
          end
        end
        ST_WAIT: begin
          if (heap_done) begin
            if (op_q == OP_POP) begin
              occ_q      <= occ_q - OCC_W'(1);
              rsp_data_q <= heap_pop_data;
            end else begin
              occ_q      <= occ_q + OCC_W'(1);
            end
          end else if (timed_out) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HEAP_SCHED_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] tmr_q;
  logic             flag_q;

  assign timed_out = (state_q == ST_WAIT) && !heap_done && (tmr_q == TMR_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      if (state_q != ST_WAIT) tmr_q <= '0;
      else if (!timed_out)    tmr_q <= tmr_q + TMR_W'(1);
      if (timed_out) flag_q <= 1'b1;
    end
  end

  assign timeout_flag = flag_q;
`else
  assign timed_out    = (TIMEOUT_CYC < 0);
  assign timeout_flag = 1'b0;
`endif

  assign heap_cmd_op   = op_q;
  assign heap_cmd_data = data_q;
  assign occupancy     = occ_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_heap_op_scheduler.sv
// tb/tb_heap_op_scheduler.sv - scoreboard bench for heap_op_scheduler with a behavioural max-heap responder
module tb_heap_op_scheduler;

  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 32;
  localparam int HEAP_DEPTH = 25;
  localparam int OCC_W      = $clog2(HEAP_DEPTH + 1);

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_op = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      heap_cmd_valid;
  logic                      heap_cmd_op;
  logic [DATA_W-1:0]         heap_cmd_data;
  logic                      heap_cmd_ready = 1'b0;
  logic                      heap_done = 1'b0;
  logic [DATA_W-1:0]         heap_pop_data = '0;
  logic [OCC_W-1:0]          occupancy;
  logic                      busy;
  logic                      timeout_flag;

  heap_op_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_op         (req_op),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .heap_cmd_valid (heap_cmd_valid),
    .heap_cmd_op    (heap_cmd_op),
    .heap_cmd_data  (heap_cmd_data),
    .heap_cmd_ready (heap_cmd_ready),
    .heap_done      (heap_done),
    .heap_pop_data  (heap_pop_data),
    .occupancy      (occupancy),
    .busy           (busy),
    .timeout_flag   (timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               id;
    bit               err;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] exp_heap[$];
  logic [DATA_W-1:0] heap_mem[$];
  int                grant_log[$];
  logic              cmd_op_log[$];
  logic [DATA_W-1:0] cmd_data_log[$];
  int                checks = 0;
  int                failures = 0;

  int ready_delay = 0;
  int done_delay  = 2;
  bit hold_done   = 1'b0;

  function automatic logic [DATA_W-1:0] take_max_exp();
    int bi = 0;
    for (int i = 1; i < exp_heap.size(); i++) if (exp_heap[i] > exp_heap[bi]) bi = i;
    take_max_exp = exp_heap[bi];
    exp_heap.delete(bi);
  endfunction

  function automatic logic [DATA_W-1:0] take_max_mem();
    int bi = 0;
    if (heap_mem.size() == 0) return '0;
    for (int i = 1; i < heap_mem.size(); i++) if (heap_mem[i] > heap_mem[bi]) bi = i;
    take_max_mem = heap_mem[bi];
    heap_mem.delete(bi);
  endfunction

  // Behavioural heap unit: accepts after ready_delay cycles, completes done_delay cycles later.
  int                hstate = 0;
  int                hcnt = 0;
  logic              pend_op = 1'b0;
  logic [DATA_W-1:0] pend_data = '0;
  always @(negedge clk) begin
    if (reset) begin
      heap_cmd_ready = 1'b0; heap_done = 1'b0; heap_pop_data = '0;
      hstate = 0; hcnt = 0; heap_mem.delete();
    end else begin
      case (hstate)
        0: begin
          heap_done = 1'b0; heap_pop_data = '0;
          if (heap_cmd_valid) begin
            if (hcnt < ready_delay) begin
              hcnt++; heap_cmd_ready = 1'b0;
            end else begin
              heap_cmd_ready = 1'b1; hcnt = 0; hstate = 1;
              pend_op = heap_cmd_op; pend_data = heap_cmd_data;
              cmd_op_log.push_back(heap_cmd_op); cmd_data_log.push_back(heap_cmd_data);
            end
          end else begin
            heap_cmd_ready = 1'b0;
          end
        end
        1: begin
          heap_cmd_ready = 1'b0;
          if (!hold_done) begin
            if (hcnt < done_delay) hcnt++;
            else begin
              hcnt = 0; hstate = 2; heap_done = 1'b1;
              if (pend_op) heap_pop_data = take_max_mem();
              else heap_mem.push_back(pend_data);
            end
          end
        end
        default: begin
          heap_done = 1'b0; heap_pop_data = '0; hstate = 0;
        end
      endcase
    end
  end

  // Scoreboard: expectation pushed on each accept, compared on each completion.
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    #1;
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (|req_ready) begin
        int   g;
        exp_t e;
        checks++;
        if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != '0) begin
          failures++;
          $display("FAIL ready_onehot: req_ready=%b req_valid=%b (need one-hot subset)", req_ready, req_valid);
        end
        g = 0;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
        grant_log.push_back(g);
        e.id = g; e.err = 1'b0; e.data = '0;
        if (req_op[g] == 1'b0) begin
          if (exp_heap.size() == HEAP_DEPTH) e.err = 1'b1;
          else exp_heap.push_back(req_data[g*DATA_W +: DATA_W]);
        end else begin
          if (exp_heap.size() == 0) e.err = 1'b1;
          else e.data = take_max_exp();
        end
        sb.push_back(e);
      end
      if (|rsp_valid) begin
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected: rsp_valid=%b with no outstanding request", rsp_valid);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== (NUM_REQ'(1) << e.id) || rsp_err !== e.err || rsp_data !== e.data) begin
            failures++;
            $display("FAIL rsp_match: got valid=%b err=%b data=%0d, want valid=%b err=%b data=%0d",
                     rsp_valid, rsp_err, rsp_data, NUM_REQ'(1) << e.id, e.err, e.data);
          end
          if (!rsp_err) begin
            checks++;
            if (!prev_done) begin
              failures++;
              $display("FAIL rsp_latency: rsp_valid=%b but heap_done was 0 the cycle before, need 1", rsp_valid);
            end
          end
        end
      end
      prev_done = heap_done;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; hold_done = 1'b0; ready_delay = 0;
    repeat (2) @(negedge clk);
    sb.delete(); exp_heap.delete(); grant_log.delete();
    cmd_op_log.delete(); cmd_data_log.delete();
    reset = 1'b0;
  endtask

  task automatic do_req(input int id, input bit op, input logic [DATA_W-1:0] d, output bit ok);
    @(negedge clk);
    req_valid[id] = 1'b1; req_op[id] = op; req_data[id*DATA_W +: DATA_W] = d;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (req_ready[id]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #2;
      if (!busy && sb.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, heap_cmd_valid, heap_cmd_op, busy, timeout_flag} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: ready=%b rsp=%b err=%b cmdv=%b op=%b busy=%b tmo=%b, need all 0",
               req_ready, rsp_valid, rsp_err, heap_cmd_valid, heap_cmd_op, busy, timeout_flag);
    end
    checks++;
    if (rsp_data !== '0 || heap_cmd_data !== '0) begin
      failures++;
      $display("FAIL reset_data: rsp_data=%0d heap_cmd_data=%0d, need 0", rsp_data, heap_cmd_data);
    end
    checks++;
    if (occupancy !== '0) begin
      failures++;
      $display("FAIL reset_occ: occupancy=%0d, need 0", occupancy);
    end
    reset = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || occupancy !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b occupancy=%0d, need 0/0", busy, occupancy);
    end
  endtask

  task automatic test_single_push();
    bit ok;
    apply_reset();
    do_req(0, 1'b0, 32'd7, ok);
    #1;
    checks++;
    if (!ok || heap_cmd_valid !== 1'b1 || heap_cmd_op !== 1'b0 || heap_cmd_data !== 32'd7) begin
      failures++;
      $display("FAIL push_cmd_n1: accepted=%b cmd_valid=%b op=%b data=%0d, need 1/1/0/7",
               ok, heap_cmd_valid, heap_cmd_op, heap_cmd_data);
    end
    wait_done(ok);
    checks++;
    if (!ok || occupancy !== OCC_W'(1)) begin
      failures++;
      $display("FAIL push_occ: done=%b occupancy=%0d, need 1/1", ok, occupancy);
    end
  endtask

  task automatic test_fairness();
    bit ok;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    @(negedge clk);
    req_op = '0;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = 32'(100 + i);
    req_valid = '1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #2;
      if (grant_log.size() >= 5) break;
    end
    @(negedge clk);
    req_valid = '0;
    wait_done(ok);
    checks++;
    if (grant_log.size() != 5 || !ok) begin
      failures++;
      $display("FAIL fair_count: grants=%0d done=%b, need 5/1", grant_log.size(), ok);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (grant_log[k] != exp_order[k]) begin
          failures++;
          $display("FAIL fair_order[%0d]: granted %0d, need %0d", k, grant_log[k], exp_order[k]);
        end
      end
    end
    checks++;
    if (occupancy !== OCC_W'(5)) begin
      failures++;
      $display("FAIL fair_occ: occupancy=%0d, need 5", occupancy);
    end
  endtask

  task automatic test_empty_pop();
    bit ok;
    apply_reset();
    do_req(2, 1'b1, '0, ok);
    #1;
    checks++;
    if (!ok || rsp_valid !== 4'b0100 || rsp_err !== 1'b1 || rsp_data !== '0 || heap_cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL empty_pop_n1: accepted=%b rsp_valid=%b err=%b data=%0d cmdv=%b, need 1/0100/1/0/0",
               ok, rsp_valid, rsp_err, rsp_data, heap_cmd_valid);
    end
    wait_done(ok);
    checks++;
    if (!ok || cmd_op_log.size() != 0 || occupancy !== '0) begin
      failures++;
      $display("FAIL empty_pop_nocmd: done=%b heap_cmds=%0d occupancy=%0d, need 1/0/0",
               ok, cmd_op_log.size(), occupancy);
    end
  endtask

  task automatic test_full_push();
    bit ok;
    bit all_ok = 1'b1;
    int ncmd;
    apply_reset();
    for (int i = 0; i < HEAP_DEPTH; i++) begin
      do_req(i % NUM_REQ, 1'b0, 32'($urandom_range(1, 1000)), ok);
      all_ok &= ok;
    end
    wait_done(ok);
    checks++;
    if (!all_ok || !ok || occupancy !== OCC_W'(HEAP_DEPTH)) begin
      failures++;
      $display("FAIL full_occ: accepted=%b done=%b occupancy=%0d, need 1/1/%0d", all_ok, ok, occupancy, HEAP_DEPTH);
    end
    ncmd = cmd_op_log.size();
    do_req(1, 1'b0, 32'd99, ok);
    #1;
    checks++;
    if (!ok || rsp_valid !== 4'b0010 || rsp_err !== 1'b1) begin
      failures++;
      $display("FAIL full_reject_n1: accepted=%b rsp_valid=%b err=%b, need 1/0010/1", ok, rsp_valid, rsp_err);
    end
    wait_done(ok);
    checks++;
    if (occupancy !== OCC_W'(HEAP_DEPTH) || cmd_op_log.size() != ncmd) begin
      failures++;
      $display("FAIL full_hold: occupancy=%0d heap_cmds=%0d, need %0d/%0d",
               occupancy, cmd_op_log.size(), HEAP_DEPTH, ncmd);
    end
    do_req(3, 1'b1, '0, ok);
    wait_done(ok);
    checks++;
    if (!ok || occupancy !== OCC_W'(HEAP_DEPTH - 1)) begin
      failures++;
      $display("FAIL pop_occ: done=%b occupancy=%0d, need 1/%0d", ok, occupancy, HEAP_DEPTH - 1);
    end
  endtask

  task automatic test_stall_reset();
    bit ok;
    int bad = 0;
    apply_reset();
    do_req(0, 1'b0, 32'd11, ok);
    wait_done(ok);
    ready_delay = 10;
    hold_done   = 1'b1;
    do_req(3, 1'b0, 32'hA5A5_0001, ok);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (heap_cmd_valid !== 1'b1 || heap_cmd_op !== 1'b0 || heap_cmd_data !== 32'hA5A5_0001) bad++;
      @(negedge clk);
    end
    checks++;
    if (!ok || bad != 0) begin
      failures++;
      $display("FAIL stall_stable: accepted=%b unstable_cycles=%0d, need 1/0", ok, bad);
    end
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (busy && !heap_cmd_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reach_wait: busy=%b cmd_valid=%b, need 1/0", busy, heap_cmd_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, heap_cmd_valid, busy, timeout_flag} !== '0 ||
        occupancy !== '0 || rsp_data !== '0 || heap_cmd_data !== '0) begin
      failures++;
      $display("FAIL reset_in_wait: busy=%b cmdv=%b occ=%0d cmd_data=%0d rsp=%b, need all 0",
               busy, heap_cmd_valid, occupancy, heap_cmd_data, rsp_valid);
    end
    hold_done = 1'b0; ready_delay = 0;
    repeat (2) @(negedge clk);
    sb.delete(); exp_heap.delete(); grant_log.delete();
    reset = 1'b0;
    do_req(1, 1'b0, 32'd5, ok);
    wait_done(ok);
    checks++;
    if (!ok || occupancy !== OCC_W'(1)) begin
      failures++;
      $display("FAIL after_reset_push: done=%b occupancy=%0d, need 1/1", ok, occupancy);
    end
  endtask

`ifdef HEAP_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    apply_reset();
    do_req(0, 1'b0, 32'd10, ok);
    wait_done(ok);
    hold_done = 1'b1;
    do_req(1, 1'b0, 32'd555, ok);
    if (sb.size() > 0) sb[sb.size()-1].err = 1'b1;
    if (exp_heap.size() > 0) void'(exp_heap.pop_back());
    wait_done(ok);
    checks++;
    if (!ok || timeout_flag !== 1'b1 || occupancy !== OCC_W'(1)) begin
      failures++;
      $display("FAIL timeout: done=%b timeout_flag=%b occupancy=%0d, need 1/1/1", ok, timeout_flag, occupancy);
    end
    apply_reset();
    #1;
    checks++;
    if (timeout_flag !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: timeout_flag=%b, need 0", timeout_flag);
    end
  endtask
`else
  task automatic test_no_timeout();
    bit ok;
    apply_reset();
    hold_done = 1'b1;
    do_req(1, 1'b0, 32'd555, ok);
    repeat (100) @(negedge clk);
    #2;
    checks++;
    if (!ok || busy !== 1'b1 || timeout_flag !== 1'b0) begin
      failures++;
      $display("FAIL wait_holds: accepted=%b busy=%b timeout_flag=%b, need 1/1/0", ok, busy, timeout_flag);
    end
    hold_done = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok || occupancy !== OCC_W'(1)) begin
      failures++;
      $display("FAIL late_done: done=%b occupancy=%0d, need 1/1", ok, occupancy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_push();
    test_fairness();
    test_empty_pop();
    test_full_push();
    test_stall_reset();
`ifdef HEAP_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
